iopage_ctl: RTL and testbench

Unibus-style I/O-page access controller between the CPU bus master and the I/O-page device registers (switch register at 17777570 and its peers). Detects accesses to the top 8 KB of the 22-bit physical space and presents them to devices as a 13-bit `iopage_addr` with `iopage_rd`/`iopage_wr`/`iopage_byte_op` strobes. Collects each device's `decode` and `data_out`, steers byte lanes, and returns an acknowledge. If no device decodes within a bounded time, it returns a non-existent-memory (NXM) response instead.

---
 rtl/pdp11_iopage_pkg.sv | 16 +
 rtl/iopage_rdmux.sv | 21 ++
 rtl/iopage_ctl.sv | 153 +++++++++++++++
 tb/tb_iopage_ctl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pdp11_iopage_pkg.sv
// Shared types and constants for the I/O-page access controller.
package pdp11_iopage_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ACCESS,
    ST_DONE,
    ST_NXM,
    ST_RELEASE
  } iopage_state_t;

  localparam logic [8:0]  IOPAGE_PREFIX = 9'o777;
  localparam logic [12:0] SR_ADDR       = 13'o17570;

endpackage

// File: rtl/iopage_rdmux.sv
// Lowest-index priority select of device read data, plus an any-decode flag.
module iopage_rdmux #(
  parameter int N_DEV = 4
) (
  input  logic [N_DEV-1:0]    dev_decode_i,
  input  logic [16*N_DEV-1:0] dev_data_i,
  output logic [15:0]         rdata_o,
  output logic                any_hit_o
);

  // Walk from the top so the lowest decoding index is written last and wins.
  always_comb begin
    rdata_o = '0;
    for (int i = N_DEV - 1; i >= 0; i--) begin
      if (dev_decode_i[i]) rdata_o = dev_data_i[16*i +: 16];
    end
  end

  assign any_hit_o = |dev_decode_i;

endmodule

// File: rtl/iopage_ctl.sv
// I/O-page access controller: decodes top-8KB accesses, strobes devices,
// collects decode/data and returns ack or NXM after a bounded wait.
module iopage_ctl
  import pdp11_iopage_pkg::*;
#(
  parameter int N_DEV   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [21:0]         bus_addr,
  input  logic                bus_rd,
  input  logic                bus_wr,
  input  logic                bus_byte_op,
  input  logic [15:0]         bus_data_in,
  output logic [15:0]         bus_data_out,
  output logic                bus_ack,
  output logic                bus_nxm,
  output logic                busy,
  output logic [12:0]         iopage_addr,
  output logic                iopage_rd,
  output logic                iopage_wr,
  output logic                iopage_byte_op,
  output logic [15:0]         iopage_data_out,
  input  logic [N_DEV-1:0]    dev_decode,
  input  logic [16*N_DEV-1:0] dev_data
);

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  iopage_state_t state_q, state_d;
  logic [12:0] addr_q, addr_d;
  logic        byte_q, byte_d;
  logic        wdir_q, wdir_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        ack_q, ack_d;
  logic        nxm_q, nxm_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic        busy_q, busy_d;

  logic [15:0] sel_data;
  logic        any_hit;
  logic        hit;

  iopage_rdmux #(.N_DEV(N_DEV)) u_rdmux (
    .dev_decode_i (dev_decode),
    .dev_data_i   (dev_data),
    .rdata_o      (sel_data),
    .any_hit_o    (any_hit)
  );

  assign hit = (bus_addr[21:13] == IOPAGE_PREFIX);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    byte_d  = byte_q;
    wdir_d  = wdir_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (hit && (bus_rd || bus_wr)) begin
          addr_d  = bus_addr[12:0];
          byte_d  = bus_byte_op;
          wdir_d  = !bus_rd;
          wdata_d = bus_byte_op ? {2{bus_data_in[7:0]}} : bus_data_in;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        cnt_d   = '0;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (any_hit) begin
          if (!wdir_q) begin
            if (byte_q) rdata_d = {8'h00, addr_q[0] ? sel_data[15:8] : sel_data[7:0]};
            else        rdata_d = sel_data;
          end
          state_d = ST_DONE;
        end else begin
          cnt_d = sat_inc(cnt_q);
          // Clear read data on the way into NXM so the timeout cycle shows zero.
          if (cnt_d >= TIMEOUT_C) begin
            rdata_d = '0;
            state_d = ST_NXM;
          end
        end
      end
      ST_DONE:    state_d = ST_RELEASE;
      ST_NXM:     state_d = ST_RELEASE;
      ST_RELEASE: if (!bus_rd && !bus_wr) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    ack_d  = (state_d == ST_DONE);
    nxm_d  = (state_d == ST_NXM);
    rd_d   = (state_d == ST_ACCESS) && !wdir_d;
    wr_d   = (state_d == ST_ACCESS) && wdir_d;
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      byte_q  <= 1'b0;
      wdir_q  <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      nxm_q   <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      byte_q  <= byte_d;
      wdir_q  <= wdir_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      nxm_q   <= nxm_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
    end
  end

  assign bus_data_out    = rdata_q;
  assign bus_ack         = ack_q;
  assign bus_nxm         = nxm_q;
  assign busy            = busy_q;
  assign iopage_addr     = addr_q;
  assign iopage_rd       = rd_q;
  assign iopage_wr       = wr_q;
  assign iopage_byte_op  = byte_q;
  assign iopage_data_out = wdata_q;

endmodule

// File: tb/tb_iopage_ctl.sv
// Directed bench for iopage_ctl with four modelled I/O-page devices.
module tb_iopage_ctl;
  import pdp11_iopage_pkg::*;

  localparam int N_DEV = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic [21:0]         bus_addr;
  logic                bus_rd, bus_wr, bus_byte_op;
  logic [15:0]         bus_data_in;
  logic [15:0]         bus_data_out;
  logic                bus_ack, bus_nxm, busy;
  logic [12:0]         iopage_addr;
  logic                iopage_rd, iopage_wr, iopage_byte_op;
  logic [15:0]         iopage_data_out;
  logic [N_DEV-1:0]    dev_decode;
  logic [16*N_DEV-1:0] dev_data;

  logic [12:0] dev_match [N_DEV];
  logic [15:0] dev_val   [N_DEV];

  int total = 0;
  int bad   = 0;
  int rd_cnt, wr_cnt, ack_cnt, nxm_cyc, busy_seen;

  iopage_ctl #(.N_DEV(N_DEV), .TIMEOUT(15)) dut (
    .clk             (clk),
    .reset           (reset),
    .bus_addr        (bus_addr),
    .bus_rd          (bus_rd),
    .bus_wr          (bus_wr),
    .bus_byte_op     (bus_byte_op),
    .bus_data_in     (bus_data_in),
    .bus_data_out    (bus_data_out),
    .bus_ack         (bus_ack),
    .bus_nxm         (bus_nxm),
    .busy            (busy),
    .iopage_addr     (iopage_addr),
    .iopage_rd       (iopage_rd),
    .iopage_wr       (iopage_wr),
    .iopage_byte_op  (iopage_byte_op),
    .iopage_data_out (iopage_data_out),
    .dev_decode      (dev_decode),
    .dev_data        (dev_data)
  );

  always #5 clk = ~clk;

  always_comb begin
    dev_decode = '0;
    dev_data   = '0;
    for (int i = 0; i < N_DEV; i++) begin
      dev_decode[i]       = (iopage_addr == dev_match[i]);
      dev_data[16*i +: 16] = dev_val[i];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [21:0] a, input logic rd, input logic wr,
                     input logic bo, input logic [15:0] d);
    bus_addr = a; bus_rd = rd; bus_wr = wr; bus_byte_op = bo; bus_data_in = d;
  endtask

  task automatic drop();
    bus_rd = 1'b0; bus_wr = 1'b0;
  endtask

  initial begin
    dev_match[0] = SR_ADDR;     dev_val[0] = 16'o0;
    dev_match[1] = 13'o17572;   dev_val[1] = 16'h1111;
    dev_match[2] = 13'o17572;   dev_val[2] = 16'h2222;
    dev_match[3] = 13'o17571;   dev_val[3] = 16'hA55A;
    req(22'o0, 1'b0, 1'b0, 1'b0, 16'h0);
    reset = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_ack", bus_ack, 0);
    check("rst_nxm", bus_nxm, 0);
    check("rst_rd", iopage_rd, 0);
    check("rst_wr", iopage_wr, 0);
    check("rst_bo", iopage_byte_op, 0);
    check("rst_addr", iopage_addr, 0);
    check("rst_wdata", iopage_data_out, 0);
    check("rst_rdata", bus_data_out, 0);
    tick(); tick();
    reset = 1'b1;
    tick();

    // Word read of switch register
    req(22'o17777570, 1'b1, 1'b0, 1'b0, 16'h0);
    tick();
    check("sr_c1_rd", iopage_rd, 0);
    check("sr_c1_busy", busy, 1);
    check("sr_c1_addr", iopage_addr, 13'o17570);
    tick();
    check("sr_c2_rd", iopage_rd, 1);
    check("sr_c2_ack", bus_ack, 0);
    tick();
    check("sr_c3_ack", bus_ack, 1);
    check("sr_c3_rd", iopage_rd, 0);
    check("sr_c3_data", bus_data_out, 16'o0);
    drop();
    tick();
    check("sr_c4_ack", bus_ack, 0);
    check("sr_c4_busy", busy, 1);
    tick();
    check("sr_c5_busy", busy, 0);

    // Byte read, odd address -> high byte
    req(22'o17777571, 1'b1, 1'b0, 1'b1, 16'h0);
    tick(); tick(); tick();
    check("br_ack", bus_ack, 1);
    check("br_data", bus_data_out, 16'h00A5);
    drop();
    tick(); tick();

    // Byte write
    req(22'o17777570, 1'b0, 1'b1, 1'b1, 16'h1234);
    tick();
    check("bw_c1_wr", iopage_wr, 0);
    tick();
    check("bw_c2_wr", iopage_wr, 1);
    check("bw_c2_rd", iopage_rd, 0);
    check("bw_c2_wdata", iopage_data_out, 16'h3434);
    check("bw_c2_bo", iopage_byte_op, 1);
    tick();
    check("bw_c3_ack", bus_ack, 1);
    check("bw_c3_wr", iopage_wr, 0);
    drop();
    tick(); tick();

    // NXM timeout with request held throughout
    req(22'o17777000, 1'b1, 1'b0, 1'b0, 16'h0);
    rd_cnt = 0; ack_cnt = 0; nxm_cyc = 0;
    for (int c = 1; c <= 25; c++) begin
      tick();
      if (iopage_rd) rd_cnt++;
      if (bus_ack) ack_cnt++;
      if (bus_nxm && nxm_cyc == 0) begin
        nxm_cyc = c;
        check("nxm_data", bus_data_out, 16'h0);
      end
    end
    check("nxm_rd_cycles", rd_cnt, 15);
    check("nxm_cycle", nxm_cyc, 17);
    check("nxm_no_ack", ack_cnt, 0);
    check("nxm_held_busy", busy, 1);
    drop();
    tick(); tick();
    check("nxm_idle", busy, 0);

    // Non-I/O-page request is ignored
    req(22'o00001000, 1'b1, 1'b0, 1'b0, 16'h0);
    busy_seen = 0; rd_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (busy) busy_seen++;
      if (iopage_rd || iopage_wr) rd_cnt++;
    end
    check("nonio_busy", busy_seen, 0);
    check("nonio_strobe", rd_cnt, 0);
    drop();
    tick();

    // Two decoders: lowest index wins; held request executes once
    req(22'o17777572, 1'b1, 1'b0, 1'b0, 16'h0);
    rd_cnt = 0; ack_cnt = 0;
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (iopage_rd) rd_cnt++;
      if (bus_ack) ack_cnt++;
      if (c == 3) check("prio_data", bus_data_out, 16'h1111);
    end
    check("held_rd_once", rd_cnt, 1);
    check("held_ack_once", ack_cnt, 1);
    check("held_busy", busy, 1);
    drop();
    tick(); tick();
    check("held_idle", busy, 0);

    // Word read at odd address, request dropped mid-cycle
    req(22'o17777571, 1'b1, 1'b0, 1'b0, 16'h0);
    tick(); tick();
    drop();
    tick();
    check("odd_ack", bus_ack, 1);
    check("odd_data", bus_data_out, 16'hA55A);
    tick(); tick();
    check("odd_idle", busy, 0);

    // Reset during ACCESS
    req(22'o17777570, 1'b1, 1'b0, 1'b0, 16'h0);
    tick(); tick();
    check("rstacc_rd_before", iopage_rd, 1);
    #2 reset = 1'b0;
    #1;
    check("rstacc_rd", iopage_rd, 0);
    check("rstacc_busy", busy, 0);
    check("rstacc_ack", bus_ack, 0);
    drop();
    tick();
    check("rstacc_held_ack", bus_ack, 0);
    reset = 1'b1;
    tick();
    dev_val[0] = 16'o123;
    req(22'o17777570, 1'b1, 1'b0, 1'b0, 16'h0);
    tick(); tick();
    check("post_rd", iopage_rd, 1);
    tick();
    check("post_ack", bus_ack, 1);
    check("post_data", bus_data_out, 16'o123);
    drop();
    tick(); tick();
    check("post_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
